elbeth_dpram: RTL and testbench

Parametrised dual-port, byte-writable RAM that succeeds `elbeth_memory` as the ELBETH core's instruction/data store. Port A and port B are independent request/ready channels with byte-lane write enables. Each port has a configurable access latency. Same-address, same-edge collisions have defined resolution and are flagged on a `collision` output. The block sits between the core's fetch/load-store units and the memory array.

---
 rtl/elbeth_mem_defs.sv | 9 +
 rtl/elbeth_mem_port_ctrl.sv | 44 ++++
 rtl/elbeth_dpram.sv | 58 +++++
 tb/tb_elbeth_dpram.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/elbeth_mem_defs.sv
// elbeth_mem_defs: shared state encodings and counter width for the ELBETH dual-port RAM.
package elbeth_mem_defs;
  localparam int MEM_LAT_W = 4;
  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_t;
endpackage

// File: rtl/elbeth_mem_port_ctrl.sv
// elbeth_mem_port_ctrl: per-port request FSM, latency counter and result latch.
module elbeth_mem_port_ctrl
  import elbeth_mem_defs::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  accept,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] dout
);
  localparam logic [MEM_LAT_W-1:0] LOAD = MEM_LAT_W'(LATENCY - 1);
  localparam logic [MEM_LAT_W-1:0] ONE  = MEM_LAT_W'(1);
  mem_state_t state, state_n;
  logic [MEM_LAT_W-1:0] cnt, cnt_n;
  logic [DATA_WIDTH-1:0] pend;
  logic last;
  assign accept = enable && !rst && state != MEM_WAIT;
  assign ready  = state == MEM_DONE;
  assign last   = state == MEM_WAIT && cnt == ONE;
  always_comb begin
    state_n = accept ? (LATENCY == 1 ? MEM_DONE : MEM_WAIT) :
              state == MEM_WAIT ? (last ? MEM_DONE : MEM_WAIT) : MEM_IDLE;
    cnt_n   = accept ? LOAD : state == MEM_WAIT ? cnt - ONE : cnt;
  end
  // The result is captured at acceptance but only exposed when the access completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MEM_IDLE;
      cnt   <= '0;
      pend  <= '0;
      dout  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pend  <= accept ? din : pend;
      dout  <= (accept && LATENCY == 1) ? din : last ? pend : dout;
    end
  end
endmodule

// File: rtl/elbeth_dpram.sv
// elbeth_dpram: dual-port byte-writable RAM with per-port latency and collision flag.
module elbeth_dpram
  import elbeth_mem_defs::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_enable,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [DATA_WIDTH-1:0]   a_data_in,
  input  logic [DATA_WIDTH/8-1:0] a_wr,
  output logic [DATA_WIDTH-1:0]   a_data_out,
  output logic                    a_ready,
  input  logic                    b_enable,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  input  logic [DATA_WIDTH-1:0]   b_data_in,
  input  logic [DATA_WIDTH/8-1:0] b_wr,
  output logic [DATA_WIDTH-1:0]   b_data_out,
  output logic                    b_ready,
  output logic                    collision
);
  localparam int NB = DATA_WIDTH / 8;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic a_acc, b_acc, same;
  logic [DATA_WIDTH-1:0] a_word, b_word;
  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old,
                                                  input logic [DATA_WIDTH-1:0] din,
                                                  input logic [NB-1:0] wr);
    merge = old;
    for (int i = 0; i < NB; i++)
      if (wr[i]) merge[8*i+:8] = din[8*i+:8];
  endfunction
  assign same = a_addr == b_addr;
  // B lanes first, then A lanes, so A wins any lane both ports write.
  assign a_word = merge(merge(mem[a_addr], b_data_in, (b_acc && same) ? b_wr : '0),
                        a_data_in, a_acc ? a_wr : '0);
  assign b_word = merge(merge(mem[b_addr], b_data_in, b_acc ? b_wr : '0),
                        a_data_in, (a_acc && same) ? a_wr : '0);
  always_ff @(posedge clk) begin
    if (a_acc && |a_wr) mem[a_addr] <= a_word;
    if (b_acc && |b_wr) mem[b_addr] <= b_word;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) collision <= 1'b0;
    else     collision <= a_acc && b_acc && same && (|a_wr || |b_wr);
  end
  elbeth_mem_port_ctrl #(.DATA_WIDTH(DATA_WIDTH), .LATENCY(LATENCY)) u_a (
    .clk(clk), .rst(rst), .enable(a_enable), .din(a_word),
    .accept(a_acc), .ready(a_ready), .dout(a_data_out)
  );
  elbeth_mem_port_ctrl #(.DATA_WIDTH(DATA_WIDTH), .LATENCY(LATENCY)) u_b (
    .clk(clk), .rst(rst), .enable(b_enable), .din(b_word),
    .accept(b_acc), .ready(b_ready), .dout(b_data_out)
  );
endmodule

// File: tb/tb_elbeth_dpram.sv
// tb_elbeth_dpram: table, random and hand-sequenced checks on LATENCY=1 and LATENCY=3 instances.
module tb_elbeth_dpram;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic a_en = 0, b_en = 0;
  logic [7:0] a_addr = 0, b_addr = 0;
  logic [31:0] a_din = 0, b_din = 0;
  logic [3:0] a_wr = 0, b_wr = 0;
  logic [31:0] a_out, b_out;
  logic a_rdy, b_rdy, col;

  logic t_a_en = 0, t_b_en = 0;
  logic [7:0] t_a_addr = 0, t_b_addr = 0;
  logic [31:0] t_a_din = 0, t_b_din = 0;
  logic [3:0] t_a_wr = 0, t_b_wr = 0;
  logic [31:0] t_a_out, t_b_out;
  logic t_a_rdy, t_b_rdy, t_col;

  elbeth_dpram #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .a_enable(a_en), .a_addr(a_addr), .a_data_in(a_din), .a_wr(a_wr),
    .a_data_out(a_out), .a_ready(a_rdy),
    .b_enable(b_en), .b_addr(b_addr), .b_data_in(b_din), .b_wr(b_wr),
    .b_data_out(b_out), .b_ready(b_rdy), .collision(col));

  elbeth_dpram #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst),
    .a_enable(t_a_en), .a_addr(t_a_addr), .a_data_in(t_a_din), .a_wr(t_a_wr),
    .a_data_out(t_a_out), .a_ready(t_a_rdy),
    .b_enable(t_b_en), .b_addr(t_b_addr), .b_data_in(t_b_din), .b_wr(t_b_wr),
    .b_data_out(t_b_out), .b_ready(t_b_rdy), .collision(t_col));

  typedef struct {
    logic ae; logic [7:0] aa; logic [31:0] ad; logic [3:0] aw;
    logic be; logic [7:0] ba; logic [31:0] bd; logic [3:0] bw;
    logic ar; logic [31:0] ao; logic br; logic [31:0] bo; logic c;
  } vec_t;
  vec_t tbl [14];

  int n_vec = 0, n_bad = 0;
  logic [31:0] mem_m [256];
  logic [31:0] ea = 0, eb = 0;
  logic m_ar, m_br, m_col;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mrg(input logic [31:0] w, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    r = w;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i+:8] = d[8*i+:8];
    return r;
  endfunction

  function automatic logic [31:0] pre(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, b, b, b} ^ 32'h5A5A0F0F;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one edge on the LATENCY=1 instance and advances the reference memory.
  task automatic step1(input logic ae, input logic [7:0] aa, input logic [31:0] ad, input logic [3:0] aw,
                       input logic be, input logic [7:0] ba, input logic [31:0] bd, input logic [3:0] bw);
    a_en = ae; a_addr = aa; a_din = ad; a_wr = aw;
    b_en = be; b_addr = ba; b_din = bd; b_wr = bw;
    m_col = ae && be && aa == ba && (aw != 0 || bw != 0);
    if (be) mem_m[ba] = mrg(mem_m[ba], bd, bw);
    if (ae) mem_m[aa] = mrg(mem_m[aa], ad, aw);
    if (ae) ea = mem_m[aa];
    if (be) eb = mem_m[ba];
    m_ar = ae; m_br = be;
    tick();
  endtask

  initial begin
    tbl[0]  = '{1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd1, 32'h00000000, 4'hF, 1'b0, 32'h0, 1'b1, 32'h00000000, 1'b0};
    tbl[1]  = '{1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd1, 32'h0000FFFF, 4'h3, 1'b0, 32'h0, 1'b1, 32'h0000FFFF, 1'b0};
    tbl[2]  = '{1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd1, 32'hAABBCCDD, 4'h8, 1'b0, 32'h0, 1'b1, 32'hAA00FFFF, 1'b0};
    tbl[3]  = '{1'b1, 8'd1, 32'h0, 4'h0, 1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 32'hAA00FFFF, 1'b0, 32'hAA00FFFF, 1'b0};
    tbl[4]  = '{1'b1, 8'd5, 32'h0, 4'hF, 1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 32'h00000000, 1'b0, 32'hAA00FFFF, 1'b0};
    tbl[5]  = '{1'b1, 8'd5, 32'h11111111, 4'h3, 1'b1, 8'd5, 32'h22222222, 4'h6, 1'b1, 32'h00221111, 1'b1, 32'h00221111, 1'b1};
    tbl[6]  = '{1'b1, 8'd7, 32'h12345678, 4'hF, 1'b1, 8'd9, 32'h0, 4'h0, 1'b1, 32'h12345678, 1'b1, 32'h53530606, 1'b0};
    tbl[7]  = '{1'b1, 8'd0, 32'h0, 4'h0, 1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 32'h5A5A0F0F, 1'b0, 32'h53530606, 1'b0};
    tbl[8]  = '{1'b1, 8'd1, 32'h0, 4'h0, 1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 32'hAA00FFFF, 1'b0, 32'h53530606, 1'b0};
    tbl[9]  = '{1'b1, 8'd2, 32'h0, 4'h0, 1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 32'h58580D0D, 1'b0, 32'h53530606, 1'b0};
    tbl[10] = '{1'b1, 8'd3, 32'h0, 4'h0, 1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 32'h59590C0C, 1'b0, 32'h53530606, 1'b0};
    tbl[11] = '{1'b0, 8'd0, 32'h0, 4'h0, 1'b0, 8'd0, 32'h0, 4'h0, 1'b0, 32'h59590C0C, 1'b0, 32'h53530606, 1'b0};
    tbl[12] = '{1'b1, 8'd5, 32'h0, 4'h0, 1'b1, 8'd5, 32'h0, 4'h0, 1'b1, 32'h00221111, 1'b1, 32'h00221111, 1'b0};
    tbl[13] = '{1'b1, 8'd7, 32'h0, 4'h0, 1'b1, 8'd7, 32'h000000EE, 4'h1, 1'b1, 32'h123456EE, 1'b1, 32'h123456EE, 1'b1};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 256; i++) step1(1'b1, 8'(i), pre(i), 4'hF, 1'b0, 8'd0, 32'h0, 4'h0);
    step1(1'b0, 8'd0, 32'h0, 4'h0, 1'b0, 8'd0, 32'h0, 4'h0);

    rst = 1'b1;
    #1;
    chk("reset a_ready", {31'b0, a_rdy}, 32'd0);
    chk("reset a_data_out", a_out, 32'd0);
    chk("reset b_data_out", b_out, 32'd0);
    chk("reset collision", {31'b0, col}, 32'd0);
    ea = 0; eb = 0;
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      step1(tbl[i].ae, tbl[i].aa, tbl[i].ad, tbl[i].aw, tbl[i].be, tbl[i].ba, tbl[i].bd, tbl[i].bw);
      chk($sformatf("vec%0d a_ready", i), {31'b0, a_rdy}, {31'b0, tbl[i].ar});
      chk($sformatf("vec%0d a_data_out", i), a_out, tbl[i].ao);
      chk($sformatf("vec%0d b_ready", i), {31'b0, b_rdy}, {31'b0, tbl[i].br});
      chk($sformatf("vec%0d b_data_out", i), b_out, tbl[i].bo);
      chk($sformatf("vec%0d collision", i), {31'b0, col}, {31'b0, tbl[i].c});
    end

    for (int i = 0; i < 400; i++) begin
      step1($urandom_range(0, 3) != 0, 8'($urandom_range(0, 15)), $urandom,
            $urandom_range(0, 1) != 0 ? 4'($urandom) : 4'h0,
            $urandom_range(0, 3) != 0, 8'($urandom_range(0, 15)), $urandom,
            $urandom_range(0, 1) != 0 ? 4'($urandom) : 4'h0);
      chk($sformatf("rnd%0d a_ready", i), {31'b0, a_rdy}, {31'b0, m_ar});
      chk($sformatf("rnd%0d a_data_out", i), a_out, ea);
      chk($sformatf("rnd%0d b_ready", i), {31'b0, b_rdy}, {31'b0, m_br});
      chk($sformatf("rnd%0d b_data_out", i), b_out, eb);
      chk($sformatf("rnd%0d collision", i), {31'b0, col}, {31'b0, m_col});
    end
    a_en = 0; b_en = 0;

    t_a_en = 1; t_a_addr = 8'd3; t_a_din = 32'hCAFEF00D; t_a_wr = 4'hF;
    tick();
    chk("lat3 E0 ready", {31'b0, t_a_rdy}, 32'd0);
    t_a_addr = 8'd4; t_a_din = 32'h0;
    tick();
    chk("lat3 E1 ready", {31'b0, t_a_rdy}, 32'd0);
    t_a_addr = 8'd3; t_a_wr = 4'h0;
    tick();
    chk("lat3 E2 ready", {31'b0, t_a_rdy}, 32'd1);
    chk("lat3 E2 data", t_a_out, 32'hCAFEF00D);
    tick();
    chk("lat3 E3 ready", {31'b0, t_a_rdy}, 32'd0);
    chk("lat3 E3 data hold", t_a_out, 32'hCAFEF00D);
    t_a_wr = 4'hF;
    tick();
    chk("lat3 E4 ready", {31'b0, t_a_rdy}, 32'd0);
    t_a_wr = 4'h0; t_a_en = 0;
    tick();
    chk("lat3 E5 ready", {31'b0, t_a_rdy}, 32'd1);
    chk("lat3 E5 data", t_a_out, 32'hCAFEF00D);
    tick();
    chk("lat3 E6 ready", {31'b0, t_a_rdy}, 32'd0);

    t_a_en = 1; t_b_en = 1; t_b_addr = 8'd3; t_b_din = 32'h0; t_b_wr = 4'h1;
    tick();
    chk("rst3 collision before", {31'b0, t_col}, 32'd1);
    t_a_en = 0; t_b_en = 0;
    #2 rst = 1'b1;
    #1;
    chk("rst3 a_ready", {31'b0, t_a_rdy}, 32'd0);
    chk("rst3 a_data_out", t_a_out, 32'd0);
    chk("rst3 collision", {31'b0, t_col}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst3 no strobe %0d", i), {31'b0, t_a_rdy}, 32'd0);
    end
    t_a_en = 1; t_a_addr = 8'd3;
    tick();
    t_a_en = 0;
    chk("post-rst E0 ready", {31'b0, t_a_rdy}, 32'd0);
    tick();
    chk("post-rst E1 ready", {31'b0, t_a_rdy}, 32'd0);
    tick();
    chk("post-rst E2 ready", {31'b0, t_a_rdy}, 32'd1);
    chk("post-rst data kept", t_a_out, 32'hCAFEF000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
